// File: rtl/uart_tx_frame_if.sv
// Parallel-request / serial-line bundle between a transmit client and uart_tx_frame.
// The client drives the word and framing options; the transmitter drives the line and busy.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data,
        output data_valid,
        output par_en,
        output par_typ,
        input  tx_out,
        input  busy
    );

    modport slave (
        input  p_data,
        input  data_valid,
        input  par_en,
        input  par_typ,
        output tx_out,
        output busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop.
// One clk cycle is one bit period; tx_out and busy come straight from flops.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rest,
    uart_tx_frame_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt_q     <= '0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            cnt_q     <= cnt_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    // Outputs are computed for the state being entered, so the registered line
    // shows each bit in the same cycle the FSM occupies that bit's state.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        cnt_d     = cnt_q;
        tx_out_d  = 1'b1;
        busy_d    = 1'b1;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.data_valid) begin
                    state_d   = START;
                    data_d    = bus.p_data;
                    par_en_d  = bus.par_en;
                    par_typ_d = bus.par_typ;
                    tx_out_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                state_d  = DATA;
                cnt_d    = '0;
                tx_out_d = data_q[0];
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        state_d  = PARITY;
                        tx_out_d = par_typ_q ? ~^data_q : ^data_q;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    tx_out_d = data_q[cnt_q + 1'b1];
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx_out = tx_out_q;
    assign bus.busy   = busy_q;
endmodule
